// File: rtl/xcore_pkg.sv
// xcore_pkg: shared FSM state type and parity-mode constants for the XSerial transmit path
package xcore_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

endpackage

// File: rtl/xcore_sync_fifo.sv
// xcore_sync_fifo: single-clock FIFO with a level counter and synchronous flush
module xcore_sync_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push_ok, pop_ok;

    assign full_o  = level_q == LVL_W'(DEPTH);
    assign empty_o = level_q == '0;
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_q];
    assign level_o = level_q;

    // a simultaneous push and pop leaves the level unchanged
    always_comb
        level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);

    // storage array carries no reset; only entries below the level are ever read
    always_ff @(posedge clk_i)
        if (push_ok) mem_q[wr_q] <= data_i;

    // pointers wrap naturally; flush empties the queue in one cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok) rd_q <= rd_q + 1'b1;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/xserial_tx_fifo_chan.sv
// xserial_tx_fifo_chan: buffered XSerial transmitter (start, data LSB first, parity, stop bits)
module xserial_tx_fifo_chan
    import xcore_pkg::*;
#(
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 4,
    parameter int BIT_DIV     = 1,
    parameter int PARITY_MODE = PARITY_EVEN,
    parameter int STOP_BITS   = 1
) (
    input  logic                       xbus_clock,
    input  logic                       xbus_reset_n,
    input  logic [DATA_W-1:0]          frame_data,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic                       halted,
    input  logic                       flush,
    output logic                       xserial_tx_data,
    output logic                       tx_busy,
    output logic                       frame_sent,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    tx_state_e         state_q;
    logic [DIV_W-1:0]  div_q;
    logic [CNT_W-1:0]  bit_q;
    logic [DATA_W-1:0] shift_q, head;
    logic              par_q, tx_q, sent_q, tx_d;
    logic              full, empty, bit_end, frame_end, pop;

    xcore_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i  (xbus_clock),
        .rst_ni (xbus_reset_n),
        .push_i (frame_valid && frame_ready),
        .data_i (frame_data),
        .pop_i  (pop),
        .flush_i(flush),
        .data_o (head),
        .level_o(fifo_level),
        .full_o (full),
        .empty_o(empty)
    );

    assign frame_ready     = !full && !flush;
    assign bit_end         = div_q == DIV_LAST;
    assign frame_end       = state_q == STOP && bit_end && bit_q == STOP_LAST;
    assign pop             = (state_q == IDLE || frame_end) && !empty && !halted && !flush;
    assign tx_busy         = state_q != IDLE;
    assign xserial_tx_data = tx_q;
    assign frame_sent      = sent_q;

    // line value for the bit the FSM holds this cycle; registered so the line is glitch-free
    always_comb
        tx_d = flush                ? 1'b1 :
               state_q == START     ? 1'b0 :
               state_q == DATA      ? shift_q[0] :
               state_q == PARITY    ? par_q ^ (PARITY_MODE == PARITY_ODD) :
                                      1'b1;

    // frame sequencer: a pop starts a frame from IDLE or straight after the last stop bit
    always_ff @(posedge xbus_clock or negedge xbus_reset_n) begin
        if (!xbus_reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            sent_q  <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            sent_q <= frame_end && !flush;
            div_q  <= (state_q == IDLE || bit_end || flush) ? '0 : div_q + 1'b1;
            if (pop) begin
                state_q <= START;
                shift_q <= head;
                par_q   <= 1'b0;
                bit_q   <= '0;
            end else if (flush) begin
                state_q <= IDLE;
                bit_q   <= '0;
            end else if (bit_end) begin
                case (state_q)
                    START:  state_q <= DATA;
                    DATA: begin
                        shift_q <= shift_q >> 1;
                        par_q   <= par_q ^ shift_q[0];
                        bit_q   <= (bit_q == DATA_LAST) ? '0 : bit_q + 1'b1;
                        if (bit_q == DATA_LAST)
                            state_q <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end
                    PARITY: state_q <= STOP;
                    STOP: begin
                        bit_q <= frame_end ? '0 : bit_q + 1'b1;
                        if (frame_end) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xserial_tx_fifo_chan.sv
// tb_xserial_tx_fifo_chan: scoreboard bench over even/div1, odd/div4/2-stop and no-parity channels
module tb_xserial_tx_fifo_chan;

    typedef struct {
        int          d;
        logic [15:0] bits;
        int          abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       halted = 1'b0;
    logic       flush = 1'b0;
    logic [11:0] data [3];
    logic        valid [3];
    logic        ready [3];
    logic        line [3];
    logic        busy [3];
    logic        sent [3];
    logic [2:0]  level [3];

    exp_t sb [$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt [3] = '{0, 0, 0};
    int b2b [3] = '{0, 0, 0};
    int last_end [3] = '{-9, -9, -9};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    xserial_tx_fifo_chan #(.DATA_W(12), .DEPTH(4), .BIT_DIV(1), .PARITY_MODE(1), .STOP_BITS(1)) dut_even (
        .xbus_clock(clk), .xbus_reset_n(rst_n), .frame_data(data[0]), .frame_valid(valid[0]),
        .frame_ready(ready[0]), .halted(halted), .flush(flush), .xserial_tx_data(line[0]),
        .tx_busy(busy[0]), .frame_sent(sent[0]), .fifo_level(level[0]));

    xserial_tx_fifo_chan #(.DATA_W(12), .DEPTH(4), .BIT_DIV(4), .PARITY_MODE(2), .STOP_BITS(2)) dut_odd (
        .xbus_clock(clk), .xbus_reset_n(rst_n), .frame_data(data[1]), .frame_valid(valid[1]),
        .frame_ready(ready[1]), .halted(1'b0), .flush(1'b0), .xserial_tx_data(line[1]),
        .tx_busy(busy[1]), .frame_sent(sent[1]), .fifo_level(level[1]));

    xserial_tx_fifo_chan #(.DATA_W(12), .DEPTH(4), .BIT_DIV(1), .PARITY_MODE(0), .STOP_BITS(1)) dut_none (
        .xbus_clock(clk), .xbus_reset_n(rst_n), .frame_data(data[2]), .frame_valid(valid[2]),
        .frame_ready(ready[2]), .halted(1'b0), .flush(1'b0), .xserial_tx_data(line[2]),
        .tx_busy(busy[2]), .frame_sent(sent[2]), .fifo_level(level[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input int d, input logic [15:0] bits, input int abort);
        exp_t e;
        e.d = d;
        e.bits = bits;
        e.abort = abort;
        sb.push_back(e);
    endtask

    task automatic push(input int d, input logic [11:0] v);
        data[d] = v;
        valid[d] = 1'b1;
        @(negedge clk);
        valid[d] = 1'b0;
    endtask

    task automatic wait_start(input int d, input int exp_lat, input string name);
        int c = 0;
        while (line[d] !== 1'b0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({name, " start latency"}, c, exp_lat);
    endtask

    task automatic wait_done(input int d, input int n, input string name);
        int c = 0;
        while (done_cnt[d] < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk({name, " completed in time"}, done_cnt[d] >= n, 1);
    endtask

    // decodes one line cycle by cycle: each bit must hold div cycles, frame_sent only on the last
    task automatic monitor(input int d, input int div, input int len);
        exp_t e;
        logic [15:0] got;
        logic stable, sent_ok, aborted;
        forever begin
            @(negedge clk);
            if (line[d] === 1'b0) begin
                if (cyc == last_end[d] + 1) b2b[d]++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected frame dut%0d: line low with nothing queued", d);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("frame owner dut%0d", d), e.d, d);
                    got = '0;
                    stable = 1'b1;
                    sent_ok = 1'b1;
                    aborted = 1'b0;
                    for (int i = 0; i < len * div; i++) begin
                        if (i > 0) @(negedge clk);
                        if (i == e.abort) begin
                            aborted = 1'b1;
                            chk($sformatf("abort line high dut%0d", d), line[d], 1);
                            chk($sformatf("abort no frame_sent dut%0d", d), sent[d], 0);
                            break;
                        end
                        if (i % div == 0) got[i / div] = line[d];
                        else if (line[d] !== got[i / div]) stable = 1'b0;
                        if (sent[d] !== (i == len * div - 1)) sent_ok = 1'b0;
                    end
                    if (!aborted) begin
                        chk($sformatf("frame bits dut%0d", d), got, e.bits);
                        chk($sformatf("bit hold dut%0d", d), stable, 1);
                        chk($sformatf("frame_sent timing dut%0d", d), sent_ok, 1);
                        done_cnt[d]++;
                        last_end[d] = cyc;
                    end
                end
            end else begin
                chk($sformatf("idle frame_sent dut%0d", d), sent[d], 0);
            end
        end
    endtask

    initial monitor(0, 1, 15);
    initial monitor(1, 4, 16);
    initial monitor(2, 1, 14);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bb;
        for (int d = 0; d < 3; d++) begin
            data[d] = '0;
            valid[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset line", line[0], 1);
        chk("reset busy", busy[0], 0);
        chk("reset sent", sent[0], 0);
        chk("reset level", level[0], 0);
        chk("reset line odd", line[1], 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", ready[0], 1);

        // even parity, 0x0A5: popcount 4 -> parity 0
        expect_frame(0, {1'b1, 1'b0, 12'h0A5, 1'b0}, -1);
        push(0, 12'h0A5);
        wait_start(0, 2, "even 0A5");
        chk("busy during frame", busy[0], 1);
        wait_done(0, 1, "even 0A5");

        // even parity, 0x124: popcount 3 -> parity 1
        expect_frame(0, {1'b1, 1'b1, 12'h124, 1'b0}, -1);
        push(0, 12'h124);
        wait_done(0, 2, "even 124");

        // no parity: 14-bit frame
        expect_frame(2, {2'b00, 1'b1, 12'h0A5, 1'b0}, -1);
        push(2, 12'h0A5);
        wait_start(2, 2, "none 0A5");
        wait_done(2, 1, "none 0A5");

        // odd parity, 4 cycles/bit, 2 stop bits: 0x001 -> parity 0, 64 cycles
        expect_frame(1, {1'b1, 1'b1, 1'b0, 12'h001, 1'b0}, -1);
        push(1, 12'h001);
        wait_start(1, 2, "odd 001");
        wait_done(1, 1, "odd 001");
        // 0xFFF: twelve ones -> odd parity 1
        expect_frame(1, {1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0}, -1);
        push(1, 12'hFFF);
        wait_done(1, 2, "odd FFF");
        chk("odd line idle", line[1], 1);

        // fill while halted: 4 accepted, 5th dropped, nothing sent
        base = done_cnt[0];
        bb = b2b[0];
        halted = 1'b1;
        expect_frame(0, {1'b1, 1'b1, 12'h001, 1'b0}, -1);
        expect_frame(0, {1'b1, 1'b1, 12'h800, 1'b0}, -1);
        expect_frame(0, {1'b1, 1'b0, 12'hFFF, 1'b0}, -1);
        expect_frame(0, {1'b1, 1'b0, 12'h3C3, 1'b0}, -1);
        push(0, 12'h001);
        push(0, 12'h800);
        push(0, 12'hFFF);
        push(0, 12'h3C3);
        chk("full ready low", ready[0], 0);
        chk("full level", level[0], 4);
        push(0, 12'h555);
        repeat (3) @(negedge clk);
        chk("halted line idle", line[0], 1);
        chk("halted not busy", busy[0], 0);
        chk("dropped push level", level[0], 4);
        halted = 1'b0;
        for (int t = 1; t <= 46; t++) begin
            @(negedge clk);
            if (t % 15 == 1) chk($sformatf("level after pop t=%0d", t), level[0], 3 - t / 15);
            if (t % 15 == 0) chk($sformatf("level before pop t=%0d", t), level[0], 4 - t / 15);
        end
        wait_done(0, base + 4, "back-to-back");
        chk("back-to-back frames", b2b[0] - bb, 3);

        // halted raised mid-frame: current frame completes, next one waits
        base = done_cnt[0];
        expect_frame(0, {1'b1, 1'b0, 12'h7FE, 1'b0}, -1);
        expect_frame(0, {1'b1, 1'b1, 12'h124, 1'b0}, -1);
        push(0, 12'h7FE);
        push(0, 12'h124);
        repeat (4) @(negedge clk);
        halted = 1'b1;
        wait_done(0, base + 1, "halt mid-frame");
        repeat (5) @(negedge clk);
        chk("halt holds line", line[0], 1);
        chk("halt holds level", level[0], 1);
        chk("halt not busy", busy[0], 0);
        halted = 1'b0;
        wait_done(0, base + 2, "after halt release");

        // flush mid-DATA with three frames queued; a push in the flush cycle is dropped
        expect_frame(0, {1'b1, 1'b0, 12'h3C3, 1'b0}, 6);
        push(0, 12'h3C3);
        push(0, 12'h555);
        push(0, 12'h7FE);
        push(0, 12'h001);
        chk("level before flush", level[0], 3);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        data[0] = 12'h555;
        valid[0] = 1'b1;
        #1;
        chk("ready low during flush", ready[0], 0);
        @(negedge clk);
        flush = 1'b0;
        valid[0] = 1'b0;
        chk("flush line", line[0], 1);
        chk("flush level", level[0], 0);
        chk("flush busy", busy[0], 0);
        repeat (20) @(negedge clk);
        chk("flush stays idle", line[0], 1);
        chk("flush level stays", level[0], 0);

        // asynchronous reset mid-frame
        expect_frame(0, {1'b1, 1'b0, 12'h0A5, 1'b0}, 6);
        push(0, 12'h0A5);
        wait_start(0, 2, "pre-reset");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset line", line[0], 1);
        chk("async reset busy", busy[0], 0);
        chk("async reset sent", sent[0], 0);
        chk("async reset level", level[0], 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready after async reset", ready[0], 1);
        repeat (20) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
